// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the regfile write-port control slice.
// Also provides the index-width helper used by the arbiters.
package regfile_ctrl_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ sources, flat reg/data slices.
// master = requesters, slave = arbiter.
interface regfile_wb_arbiter_if
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = ADDR_WIDTH,
  parameter int DW      = DATA_WIDTH
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_reg;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap.
// Grants are suppressed while rst is high; ptr advances past each grant.
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  vld
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_q) + k) % N);
      if (!vld && !rst && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (vld) begin
      ptr_q <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port sequencer: round-robin writeback arbitration,
// one-cycle registered write stage and a per-register busy scoreboard.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = regfile_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                        clock,
  input  logic                        ctrl_reset,
  regfile_wb_arbiter_if.slave         wb,
  output logic                        ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]       ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]       data_writeReg,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  input  logic                        rsv_valid,
  input  logic [ADDR_WIDTH-1:0]       rsv_reg,
  output logic                        rsv_stall,
  input  logic [ADDR_WIDTH-1:0]       ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]       ctrl_readRegB,
  output logic                        busy_A,
  output logic                        busy_B
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam int GW    = idx_w(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] R0 =
    ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REQ-1:0]    gnt;
  logic [GW-1:0]         gidx;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] wreg_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [GW-1:0]         gid_q;
  logic [NREGS-1:0]      busy_q, busy_d;
  logic                  rsv_take;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk (clock),
    .rst (ctrl_reset),
    .req (wb.req_valid),
    .gnt (gnt),
    .idx (gidx),
    .vld (hs)
  );

  assign wb.req_ready = gnt;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_reg  = wb.req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reservation check uses current state only; a same-edge clear
  // does not let a reservation through early.
  assign rsv_stall = rsv_valid & (rsv_reg != R0) & busy_q[rsv_reg];
  assign rsv_take  = rsv_valid & (rsv_reg != R0) & ~busy_q[rsv_reg];

  assign busy_A = busy_q[ctrl_readRegA] & (ctrl_readRegA != R0);
  assign busy_B = busy_q[ctrl_readRegB] & (ctrl_readRegB != R0);

  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[wreg_q] = 1'b0;
    if (rsv_take) busy_d[rsv_reg] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
      busy_q  <= '0;
    end else begin
      busy_q <= busy_d;
      we_q   <= hs & (sel_reg != R0);
      if (hs) begin
        wreg_q  <= sel_reg;
        wdata_q <= sel_data;
        gid_q   <= gidx;
      end
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign grant_id         = gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors with literal checks,
// plus an abstract reference model compared every cycle.
module tb_regfile_wb_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic [1:0]    grant_id;
  logic          rsv_valid;
  logic [AW-1:0] rsv_reg;
  logic          rsv_stall;
  logic [AW-1:0] ctrl_readRegA;
  logic [AW-1:0] ctrl_readRegB;
  logic          busy_A;
  logic          busy_B;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .AW(AW), .DW(DW)) wb();

  regfile_wb_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .wb               (wb.slave),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .grant_id         (grant_id),
    .rsv_valid        (rsv_valid),
    .rsv_reg          (rsv_reg),
    .rsv_stall        (rsv_stall),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .busy_A           (busy_A),
    .busy_B           (busy_B)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit run = 0;
  logic [NR-1:0] last_rdy = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state in plain variables.
  int          m_ptr = 0;
  bit          m_busy[32];
  bit          m_we = 0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  int          m_gid = 0;

  function automatic int pick();
    if (ctrl_reset) return -1;
    for (int k = 0; k < NR; k++) begin
      if (wb.req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_ready();
    int p;
    p = pick();
    return (p < 0) ? 32'd0 : (32'd1 << p);
  endfunction

  always @(posedge clock) begin
    int  p;
    bit  take;
    if (ctrl_reset) begin
      m_ptr = 0; m_we = 0; m_reg = '0; m_data = '0; m_gid = 0;
      foreach (m_busy[r]) m_busy[r] = 0;
    end else begin
      p = pick();
      take = rsv_valid && rsv_reg != 0 && !m_busy[rsv_reg];
      if (m_we) m_busy[m_reg] = 0;
      if (take) m_busy[rsv_reg] = 1;
      if (p >= 0) begin
        m_reg  = wb.req_reg[p*AW +: AW];
        m_data = wb.req_data[p*DW +: DW];
        m_we   = (m_reg != 0);
        m_gid  = p;
        m_ptr  = (p + 1) % NR;
      end else begin
        m_we = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (run) begin
      last_rdy = wb.req_ready;
      chk("m_ready", 32'(wb.req_ready), exp_ready());
      chk("m_we", 32'(ctrl_writeEnable), 32'(m_we));
      if (m_we) begin
        chk("m_wreg", 32'(ctrl_writeReg), 32'(m_reg));
        chk("m_wdata", data_writeReg, m_data);
      end
      chk("m_gid", 32'(grant_id), 32'(m_gid));
      chk("m_stall", 32'(rsv_stall),
          32'(rsv_valid && rsv_reg != 0 && m_busy[rsv_reg]));
      chk("m_busyA", 32'(busy_A),
          32'(ctrl_readRegA != 0 && m_busy[ctrl_readRegA]));
      chk("m_busyB", 32'(busy_B),
          32'(ctrl_readRegB != 0 && m_busy[ctrl_readRegB]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] r,
                         input logic [31:0] d);
    wb.req_reg[i*AW +: AW]  = r;
    wb.req_data[i*DW +: DW] = d;
  endtask

  int exp_g[4] = '{0, 1, 2, 0};

  initial begin
    ctrl_reset    = 1'b1;
    wb.req_valid  = 3'b111;
    wb.req_reg    = '0;
    wb.req_data   = '0;
    rsv_valid     = 1'b0;
    rsv_reg       = '0;
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;

    // reset held with all requesters valid
    tick();
    run = 1;
    tick();
    mid();
    chk("rst_ready", 32'(wb.req_ready), 32'd0);
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_busyA", 32'(busy_A), 32'd0);
    chk("rst_busyB", 32'(busy_B), 32'd0);

    tick();
    ctrl_reset   = 1'b0;
    wb.req_valid = 3'b000;

    // single write from requester 1
    tick();
    set_req(1, 5'd5, 32'hDEADBEEF);
    wb.req_valid = 3'b010;
    mid();
    chk("single_ready", 32'(wb.req_ready), 32'h2);
    tick();
    wb.req_valid = 3'b000;
    mid();
    chk("single_we", 32'(ctrl_writeEnable), 32'd1);
    chk("single_reg", 32'(ctrl_writeReg), 32'd5);
    chk("single_data", data_writeReg, 32'hDEADBEEF);
    chk("single_gid", 32'(grant_id), 32'd1);

    // bring pointer back to 0 with a req2 write
    tick();
    set_req(2, 5'd1, 32'h1);
    wb.req_valid = 3'b100;
    tick();
    wb.req_valid = 3'b000;

    // fairness with all three held valid
    tick();
    set_req(0, 5'd10, 32'hA0);
    set_req(1, 5'd11, 32'hB1);
    set_req(2, 5'd12, 32'hC2);
    wb.req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (n == 3) wb.req_valid = 3'b000;
      mid();
      chk("fair_gid", 32'(grant_id), 32'(exp_g[n]));
      chk("fair_we", 32'(ctrl_writeEnable), 32'd1);
    end

    // scoreboard reserve / stall / clear on r7
    tick();
    rsv_valid = 1'b1; rsv_reg = 5'd7; ctrl_readRegA = 5'd7;
    mid();
    chk("sb_stall0", 32'(rsv_stall), 32'd0);
    tick();
    mid();
    chk("sb_busy1", 32'(busy_A), 32'd1);
    chk("sb_stall1", 32'(rsv_stall), 32'd1);
    tick();
    rsv_valid = 1'b0;
    tick();
    set_req(0, 5'd7, 32'h77);
    wb.req_valid = 3'b001;
    mid();
    chk("sb_ready", 32'(wb.req_ready), 32'h1);
    tick();
    wb.req_valid = 3'b000;
    mid();
    chk("sb_we", 32'(ctrl_writeEnable), 32'd1);
    chk("sb_reg", 32'(ctrl_writeReg), 32'd7);
    chk("sb_busy_hold", 32'(busy_A), 32'd1);
    tick();
    rsv_valid = 1'b1; rsv_reg = 5'd7;
    mid();
    chk("sb_busy_clr", 32'(busy_A), 32'd0);
    chk("sb_stall2", 32'(rsv_stall), 32'd0);
    tick();
    rsv_valid = 1'b0;
    mid();
    chk("sb_busy_again", 32'(busy_A), 32'd1);

    // writes and reservations aimed at r0
    tick();
    set_req(2, 5'd0, 32'h1234);
    wb.req_valid = 3'b100;
    rsv_valid = 1'b1; rsv_reg = 5'd0; ctrl_readRegA = 5'd0;
    mid();
    chk("r0_ready", 32'(wb.req_ready), 32'h4);
    chk("r0_stall", 32'(rsv_stall), 32'd0);
    chk("r0_busyA", 32'(busy_A), 32'd0);
    tick();
    wb.req_valid = 3'b000;
    rsv_valid = 1'b0;
    mid();
    chk("r0_we", 32'(ctrl_writeEnable), 32'd0);
    chk("r0_gid", 32'(grant_id), 32'd2);

    // reset in the middle of activity
    tick();
    rsv_valid = 1'b1; rsv_reg = 5'd3;
    tick();
    rsv_reg = 5'd9;
    tick();
    rsv_valid = 1'b0;
    ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd9;
    set_req(1, 5'd2, 32'h22);
    wb.req_valid = 3'b010;
    mid();
    chk("mid_busyA", 32'(busy_A), 32'd1);
    chk("mid_busyB", 32'(busy_B), 32'd1);
    tick();
    ctrl_reset = 1'b1;
    set_req(0, 5'd4, 32'h44);
    wb.req_valid = 3'b001;
    mid();
    chk("mid_rst_ready", 32'(wb.req_ready), 32'd0);
    tick();
    ctrl_reset = 1'b0;
    wb.req_valid = 3'b000;
    mid();
    chk("mid_we", 32'(ctrl_writeEnable), 32'd0);
    chk("mid_busyA0", 32'(busy_A), 32'd0);
    chk("mid_busyB0", 32'(busy_B), 32'd0);
    tick();
    wb.req_valid = 3'b111;
    mid();
    chk("mid_ptr0", 32'(wb.req_ready), 32'h1);

    // randomized traffic that respects the hold-until-ready rule
    for (int c = 0; c < 80; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (!wb.req_valid[i] || last_rdy[i]) begin
          wb.req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, 5'($urandom_range(0, 7)), $urandom);
        end
      end
      rsv_valid     = 1'($urandom_range(0, 1));
      rsv_reg       = 5'($urandom_range(0, 7));
      ctrl_readRegA = 5'($urandom_range(0, 7));
      ctrl_readRegB = 5'($urandom_range(0, 7));
    end
    tick();
    wb.req_valid = 3'b000;
    rsv_valid = 1'b0;
    tick();
    tick();
    mid();
    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
